// File: rtl/pong_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_scheduler
// Brief    : Requests new pong object positions during vertical blanking and
//            commits them to shadow registers read by the pixel renderer.
// Revision : 1.0 - initial release
// ============================================================================
module pong_frame_scheduler #(
  parameter int X_LAST      = 767,
  parameter int Y_LAST      = 511,
  parameter int VBLANK_LINE = 480,
  parameter int COMMIT_LINE = 509
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_x,
  input  logic [8:0] counter_y,
  input  logic       update_ack,
  input  logic [8:0] next_paddle_y,
  input  logic [9:0] next_ball_x,
  input  logic [8:0] next_ball_y,
  output logic       update_req,
  output logic [8:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       overrun,
  output logic [7:0] overrun_count
);

  localparam logic [9:0] C_X_LAST   = 10'(X_LAST);
  localparam logic [8:0] C_Y_LAST   = 9'(Y_LAST);
  localparam logic [8:0] C_WIN_LINE = 9'(VBLANK_LINE - 1);
  localparam logic [8:0] C_DL_LINE  = 9'(COMMIT_LINE);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    DISPLAY   = 2'd1,
    REQ       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic line_end;
  logic frame_end;
  logic win_open;
  logic deadline;
  logic commit;
  logic miss;

  always_comb begin
    line_end  = (counter_x == C_X_LAST);
    frame_end = line_end && (counter_y == C_Y_LAST);
    win_open  = line_end && (counter_y == C_WIN_LINE);
    deadline  = line_end && (counter_y == C_DL_LINE);
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    miss       = 1'b0;
    case (state)
      WAIT_SYNC: if (frame_end) state_next = DISPLAY;
      DISPLAY:   if (win_open)  state_next = REQ;
      REQ: begin
        // An ack on the deadline edge still commits: ack has priority.
        if (update_ack) begin
          commit     = 1'b1;
          state_next = DONE;
        end else if (deadline) begin
          miss       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:      if (frame_end) state_next = DISPLAY;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_SYNC;
      update_req    <= 1'b0;
      paddle_y      <= '0;
      ball_x        <= '0;
      ball_y        <= '0;
      frame_start   <= 1'b0;
      frame_count   <= '0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state       <= state_next;
      update_req  <= (state_next == REQ);
      frame_start <= frame_end;
      overrun     <= miss;
      if (frame_end && (state != WAIT_SYNC)) begin
        frame_count <= frame_count + 8'd1;
      end
      if (miss && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (commit) begin
        paddle_y <= next_paddle_y;
        ball_x   <= next_ball_x;
        ball_y   <= next_ball_y;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_frame_scheduler
// Brief    : Scoreboard bench: directed counter sequences push expected events,
//            a negedge monitor pops and compares observed DUT events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_frame_scheduler;

  localparam int C_K_FST    = 0;
  localparam int C_K_RISE   = 1;
  localparam int C_K_FALL   = 2;
  localparam int C_K_COMMIT = 3;
  localparam int C_K_OVR    = 4;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] counter_x = '0;
  logic [8:0] counter_y = '0;
  logic       update_ack = 1'b0;
  logic [8:0] next_paddle_y = '0;
  logic [9:0] next_ball_x = '0;
  logic [8:0] next_ball_y = '0;
  logic       update_req;
  logic [8:0] paddle_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       frame_start;
  logic [7:0] frame_count;
  logic       overrun;
  logic [7:0] overrun_count;

  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  bit   mon_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [27:0] prev_sh = '0;
  logic [9:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;

  pong_frame_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .counter_x     (counter_x),
    .counter_y     (counter_y),
    .update_ack    (update_ack),
    .next_paddle_y (next_paddle_y),
    .next_ball_x   (next_ball_x),
    .next_ball_y   (next_ball_y),
    .update_req    (update_req),
    .paddle_y      (paddle_y),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .frame_start   (frame_start),
    .frame_count   (frame_count),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [8:0] y, input logic [9:0] x);
    return {13'd0, y, x};
  endfunction

  function automatic logic [31:0] sh(input logic [8:0] p, input logic [9:0] bx, input logic [8:0] by);
    return {4'd0, p, bx, by};
  endfunction

  function automatic logic [31:0] ovr(input logic [7:0] c, input logic [8:0] y, input logic [9:0] x);
    return {5'd0, c, y, x};
  endfunction

  task automatic push(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic ev(input int kind, input logic [31:0] data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d data=%h, required none (queue empty)", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        bad++;
        $display("FAIL event: got kind=%0d data=%h, required kind=%0d data=%h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Counter values visible at negedge are those the next edge will sample, so
  // an event tag names the counter position just after the causing edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_start)              ev(C_K_FST, {24'd0, frame_count});
      if (update_req && !prev_req)  ev(C_K_RISE, tag(counter_y, counter_x));
      if (!update_req && prev_req)  ev(C_K_FALL, tag(counter_y, counter_x));
      if ({paddle_y, ball_x, ball_y} != prev_sh) ev(C_K_COMMIT, {4'd0, paddle_y, ball_x, ball_y});
      if (overrun)                  ev(C_K_OVR, ovr(overrun_count, counter_y, counter_x));
    end
    prev_req <= update_req;
    prev_sh  <= {paddle_y, ball_x, ball_y};
  end

  task automatic jump(input logic [9:0] x, input logic [8:0] y);
    pos_x = x;
    pos_y = y;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      counter_x = pos_x;
      counter_y = pos_y;
      @(posedge clk);
      #1;
      if (pos_x == 10'd767) begin
        pos_x = '0;
        pos_y = pos_y + 9'd1;
      end else begin
        pos_x = pos_x + 10'd1;
      end
    end
  endtask

  task automatic set_next(input logic [8:0] p, input logic [9:0] bx, input logic [8:0] by);
    next_paddle_y = p;
    next_ball_x   = bx;
    next_ball_y   = by;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_update_req", update_req, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_overrun", overrun, 0);
    check("rst_shadows", {paddle_y, ball_x, ball_y}, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overrun_count", overrun_count, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Partial first frame with ack held high: nothing until the first frame_end.
    update_ack = 1'b1;
    set_next(9'd200, 10'd320, 9'd240);
    jump(0, 0);     adv(4);
    jump(764, 479); adv(8);
    push(C_K_FST, 32'd0);
    jump(764, 511); adv(8);
    push(C_K_RISE, tag(480, 0));
    push(C_K_FALL, tag(480, 1));
    push(C_K_COMMIT, sh(200, 320, 240));
    jump(764, 479); adv(8);
    push(C_K_FST, 32'd1);
    jump(764, 511); adv(8);
    check("frame_count_1", frame_count, 1);

    // Late ack: request held 100 cycles.
    update_ack = 1'b0;
    set_next(9'd10, 10'd20, 9'd30);
    push(C_K_RISE, tag(480, 0));
    push(C_K_FALL, tag(480, 100));
    push(C_K_COMMIT, sh(10, 20, 30));
    jump(764, 479); adv(4);
    adv(99);
    update_ack = 1'b1; adv(1);
    update_ack = 1'b0; adv(3);
    push(C_K_FST, 32'd2);
    jump(764, 511); adv(8);
    check("late_ack_no_overrun", overrun_count, 0);

    // No ack: abandoned at the deadline, shadows keep old values.
    set_next(9'd1, 10'd2, 9'd3);
    push(C_K_RISE, tag(480, 0));
    jump(764, 479); adv(8);
    push(C_K_FALL, tag(510, 0));
    push(C_K_OVR, ovr(8'd1, 510, 0));
    jump(764, 509); adv(8);
    push(C_K_FST, 32'd3);
    jump(764, 511); adv(8);

    // Ack exactly on the deadline edge wins.
    set_next(9'd4, 10'd5, 9'd6);
    push(C_K_RISE, tag(480, 0));
    jump(764, 479); adv(8);
    push(C_K_FALL, tag(510, 0));
    push(C_K_COMMIT, sh(4, 5, 6));
    jump(764, 509); adv(3);
    update_ack = 1'b1; adv(1);
    update_ack = 1'b0; adv(4);
    check("deadline_ack_count", overrun_count, 1);
    push(C_K_FST, 32'd4);
    jump(764, 511); adv(8);

    // Acks outside REQ are ignored.
    set_next(9'd7, 10'd8, 9'd9);
    update_ack = 1'b1;
    jump(0, 100); adv(4);
    update_ack = 1'b0;
    set_next(9'd11, 10'd12, 9'd13);
    jump(0, 200); adv(4);
    push(C_K_RISE, tag(480, 0));
    push(C_K_FALL, tag(480, 5));
    push(C_K_COMMIT, sh(11, 12, 13));
    jump(764, 479); adv(8);
    update_ack = 1'b1; adv(1);
    set_next(9'd14, 10'd15, 9'd16);
    adv(8);
    update_ack = 1'b0;
    check("done_ack_ignored", paddle_y, 11);
    push(C_K_FST, 32'd5);
    jump(764, 511); adv(8);

    // Reset while a request is outstanding.
    push(C_K_RISE, tag(480, 0));
    jump(764, 479); adv(8);
    push(C_K_FALL, tag(480, 5));
    push(C_K_COMMIT, sh(0, 0, 0));
    reset = 1'b1; adv(1);
    reset = 1'b0;
    check("rst_req_update_req", update_req, 0);
    check("rst_req_frame_count", frame_count, 0);
    check("rst_req_ball_x", ball_x, 0);
    adv(2);

    // 256 consecutive overruns: count saturates, frame_count wraps.
    push(C_K_FST, 32'd0);
    jump(767, 511); adv(1);
    for (int k = 1; k <= 256; k++) begin
      push(C_K_RISE, tag(509, 767));
      jump(767, 479); adv(1);
      push(C_K_FALL, tag(511, 767));
      push(C_K_OVR, ovr((k > 255) ? 8'd255 : 8'(k), 511, 767));
      jump(767, 509); adv(1);
      push(C_K_FST, {24'd0, 8'(k)});
      jump(767, 511); adv(1);
    end
    jump(0, 0); adv(2);
    check("overrun_saturated", overrun_count, 255);
    check("frame_count_wrap", frame_count, 0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
